// File: rtl/bus_master_if.sv
// Initiator-side bus interface: turns a single-cycle core access into the
// bus request/grant/strobe/ready handshake, with a watchdog abort.
module bus_master_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_as_,
  input  logic        cpu_rw,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam bit         WDOG_EN   = (TIMEOUT != 0);
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wdog;
  logic [29:0] lat_addr;
  logic        lat_rw;
  logic [31:0] lat_wr_data;
  logic        wdog_expired;

  // Core handshake: a request is presented when cpu_as_ is low; the core
  // keeps the strobe and operands stable until it sees cpu_stall low, which
  // happens only in DONE (the completion cycle) or in IDLE with no request.
  assign cpu_stall    = ((state == IDLE) && !cpu_as_) || (state == REQ) || (state == ACCESS);
  assign wdog_expired = WDOG_EN && (wdog == WDOG_LAST);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wdog        <= 8'd0;
      lat_addr    <= 30'd0;
      lat_rw      <= 1'b1;
      lat_wr_data <= 32'd0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= 30'd0;
      bus_wr_data <= 32'd0;
      cpu_rd_data <= 32'd0;
      cpu_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cpu_as_) begin
            lat_addr    <= cpu_addr;
            lat_rw      <= cpu_rw;
            lat_wr_data <= cpu_wr_data;
            bus_req_    <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (!bus_grnt_) begin
            bus_addr    <= lat_addr;
            bus_rw      <= lat_rw;
            bus_wr_data <= lat_wr_data;
            bus_as_     <= 1'b0;
            wdog        <= 8'd0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          bus_as_ <= 1'b1;
          wdog    <= wdog + 8'd1;
          // Ready takes priority over a watchdog expiry in the same cycle.
          if (!bus_rdy_) begin
            cpu_rd_data <= lat_rw ? bus_rd_data : 32'd0;
            cpu_err     <= 1'b0;
            bus_req_    <= 1'b1;
            bus_addr    <= 30'd0;
            bus_wr_data <= 32'd0;
            bus_rw      <= 1'b1;
            state       <= DONE;
          end else if (wdog_expired) begin
            cpu_rd_data <= 32'd0;
            cpu_err     <= 1'b1;
            bus_req_    <= 1'b1;
            bus_addr    <= 30'd0;
            bus_wr_data <= 32'd0;
            bus_rw      <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          cpu_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
